hazard_ctrl: RTL and testbench

- Pipeline control unit for the 5-stage RV32I core.
- Sits beside the decode stage and keeps a register scoreboard of in-flight destination registers.
- From the scoreboard, the multi-cycle execute busy flag and execute-stage redirects, it generates stall, flush, bubble and issue controls for PC, IF/ID and ID/EX.
- It is the single point that sequences the decode datapath.

---
 rtl/hazard_ctrl_if.sv | 43 ++++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Decode/writeback/execute control bundle for hazard_ctrl.
// master: pipeline side that drives decode, writeback and execute status.
// slave:  hazard_ctrl, which returns the stall/flush/bubble/issue controls.
interface hazard_ctrl_if #(
  parameter int NREGS = 32
);

  logic             id_valid_i;
  logic             id_rs1_en_i;
  logic [4:0]       id_rs1_idx_i;
  logic             id_rs2_en_i;
  logic [4:0]       id_rs2_idx_i;
  logic             id_rd_en_i;
  logic [4:0]       id_rd_idx_i;
  logic             wb_en_i;
  logic [4:0]       wb_idx_i;
  logic             ex_busy_i;
  logic             redirect_i;

  logic             pc_stall_o;
  logic             if_id_stall_o;
  logic             if_id_flush_o;
  logic             id_ex_stall_o;
  logic             id_ex_bubble_o;
  logic             issue_o;
  logic [NREGS-1:0] sb_pending_o;
  logic [1:0]       state_o;

  modport master (
    output id_valid_i, id_rs1_en_i, id_rs1_idx_i, id_rs2_en_i, id_rs2_idx_i,
           id_rd_en_i, id_rd_idx_i, wb_en_i, wb_idx_i, ex_busy_i, redirect_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
           id_ex_bubble_o, issue_o, sb_pending_o, state_o
  );

  modport slave (
    input  id_valid_i, id_rs1_en_i, id_rs1_idx_i, id_rs2_en_i, id_rs2_idx_i,
           id_rd_en_i, id_rd_idx_i, wb_en_i, wb_idx_i, ex_busy_i, redirect_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
           id_ex_bubble_o, issue_o, sb_pending_o, state_o
  );

endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage pipeline control for the 5-stage RV32I core.
// Keeps a scoreboard of in-flight destination registers and turns it, the
// execute busy flag and execute redirects into PC / IF/ID / ID/EX controls.
// Optional macro WB_BYPASS_EN: a register retiring this cycle is treated as
// not pending, so a dependent instruction may issue in the writeback cycle.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int NREGS        = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] wb_mask, set_mask, pend_eff;
  logic             hazard, in_flush;
  logic             pc_stall, if_id_stall, if_id_flush;
  logic             id_ex_stall, id_ex_bubble, issue;

  // One-hot mask of the register retiring this cycle (x0 never retires).
  always_comb begin
    wb_mask = '0;
    if (bus.wb_en_i && bus.wb_idx_i != 5'd0) wb_mask[bus.wb_idx_i] = 1'b1;
  end

  // Effective pending set seen by decode, optionally hiding the retiring register.
  always_comb begin
`ifdef WB_BYPASS_EN
    pend_eff = pending_q & ~wb_mask;
`else
    pend_eff = pending_q;
`endif
  end

  // RAW on either source or WAW on the destination against in-flight writes.
  always_comb begin
    hazard = 1'b0;
    if (bus.id_valid_i) begin
      if (bus.id_rs1_en_i && bus.id_rs1_idx_i != 5'd0 && pend_eff[bus.id_rs1_idx_i]) hazard = 1'b1;
      if (bus.id_rs2_en_i && bus.id_rs2_idx_i != 5'd0 && pend_eff[bus.id_rs2_idx_i]) hazard = 1'b1;
      if (bus.id_rd_en_i  && bus.id_rd_idx_i  != 5'd0 && pend_eff[bus.id_rd_idx_i])  hazard = 1'b1;
    end
  end

  assign in_flush = bus.redirect_i || (state_q == FLUSH);

  // Prioritised controls: flush beats busy beats hazard beats normal issue.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    issue        = 1'b0;
    if (rst_n) begin
      if (in_flush) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (bus.ex_busy_i) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
      end else if (hazard) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end else begin
        issue = bus.id_valid_i;
      end
    end
  end

  // Flush sequencing: a redirect (re)arms the counter for the extra flush cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (bus.redirect_i && FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_RELOAD;
        end
      end
      FLUSH: begin
        if (bus.redirect_i) begin
          cnt_d = FLUSH_RELOAD;
        end else if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Flush state register; reset abandons any flush in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scoreboard next value: retire clears, an issuing write sets (set wins), x0 stays clear.
  always_comb begin
    set_mask = '0;
    if (issue && bus.id_rd_en_i && bus.id_rd_idx_i != 5'd0) set_mask[bus.id_rd_idx_i] = 1'b1;
    pending_d    = (pending_q & ~wb_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  // Scoreboard register; flushes leave it alone since older writes still retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign bus.pc_stall_o     = pc_stall;
  assign bus.if_id_stall_o  = if_id_stall;
  assign bus.if_id_flush_o  = if_id_flush;
  assign bus.id_ex_stall_o  = id_ex_stall;
  assign bus.id_ex_bubble_o = id_ex_bubble;
  assign bus.issue_o        = issue;
  assign bus.sb_pending_o   = pending_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl with FLUSH_CYCLES=2.
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural scoreboard model.
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int NREGS        = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   check_count = 0;
  int   error_count = 0;

  hazard_ctrl_if #(.NREGS(NREGS)) bus ();

  hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rs1_en, input logic [4:0] rs1,
                               input logic rs2_en, input logic [4:0] rs2,
                               input logic rd_en, input logic [4:0] rd,
                               input logic wb_en, input logic [4:0] wb_idx,
                               input logic busy, input logic redir);
    bus.id_valid_i   = valid;
    bus.id_rs1_en_i  = rs1_en;
    bus.id_rs1_idx_i = rs1;
    bus.id_rs2_en_i  = rs2_en;
    bus.id_rs2_idx_i = rs2;
    bus.id_rd_en_i   = rd_en;
    bus.id_rd_idx_i  = rd;
    bus.wb_en_i      = wb_en;
    bus.wb_idx_i     = wb_idx;
    bus.ex_busy_i    = busy;
    bus.redirect_i   = redir;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
  endtask

  task automatic cycleEnd();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle();
    cycleEnd();
    rst_n = 1'b1;
  endtask

  // Behavioural model: set of in-flight registers plus remaining flush cycles.
  bit [NREGS-1:0] m_pend = '0;
  int             m_flush_left = 0;

  always @(negedge clk) begin
    bit [NREGS-1:0] eff;
    bit haz, flushing;
    bit e_pc, e_ifs, e_iff, e_exs, e_bub, e_iss;
    bit [1:0] e_state;
    e_pc = 0; e_ifs = 0; e_iff = 0; e_exs = 0; e_bub = 0; e_iss = 0; e_state = 0;
    if (!rst_n) begin
      m_pend = '0;
      m_flush_left = 0;
    end else begin
      e_state = (m_flush_left > 0) ? 2'd1 : 2'd0;
      eff = m_pend;
      if (BYPASS && bus.wb_en_i && bus.wb_idx_i != 0) eff[bus.wb_idx_i] = 1'b0;
      haz = bus.id_valid_i && (
            (bus.id_rs1_en_i && bus.id_rs1_idx_i != 0 && eff[bus.id_rs1_idx_i]) ||
            (bus.id_rs2_en_i && bus.id_rs2_idx_i != 0 && eff[bus.id_rs2_idx_i]) ||
            (bus.id_rd_en_i  && bus.id_rd_idx_i  != 0 && eff[bus.id_rd_idx_i]));
      flushing = bus.redirect_i || (m_flush_left > 0);
      if (flushing) begin
        e_iff = 1; e_bub = 1;
      end else if (bus.ex_busy_i) begin
        e_pc = 1; e_ifs = 1; e_exs = 1;
      end else if (haz) begin
        e_pc = 1; e_ifs = 1; e_bub = 1;
      end else begin
        e_iss = bus.id_valid_i;
      end
    end
    checkOutput("pc_stall", 32'(bus.pc_stall_o), 32'(e_pc));
    checkOutput("if_id_stall", 32'(bus.if_id_stall_o), 32'(e_ifs));
    checkOutput("if_id_flush", 32'(bus.if_id_flush_o), 32'(e_iff));
    checkOutput("id_ex_stall", 32'(bus.id_ex_stall_o), 32'(e_exs));
    checkOutput("id_ex_bubble", 32'(bus.id_ex_bubble_o), 32'(e_bub));
    checkOutput("issue", 32'(bus.issue_o), 32'(e_iss));
    checkOutput("sb_pending", 32'(bus.sb_pending_o), 32'(m_pend));
    checkOutput("state", 32'(bus.state_o), 32'(e_state));
    if (rst_n) begin
      if (bus.wb_en_i && bus.wb_idx_i != 0) m_pend[bus.wb_idx_i] = 1'b0;
      if (e_iss && bus.id_rd_en_i && bus.id_rd_idx_i != 0) m_pend[bus.id_rd_idx_i] = 1'b1;
      if (bus.redirect_i) m_flush_left = FLUSH_CYCLES - 1;
      else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
    end
  end

  initial begin
    // Reset holds outputs low even with a writing instruction in decode.
    rst_n = 1'b0;
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 5'd0, 0, 0);
    @(negedge clk);
    checkOutput("lit_reset_issue", 32'(bus.issue_o), 32'd0);
    checkOutput("lit_reset_sb", 32'(bus.sb_pending_o), 32'd0);
    cycleEnd();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("lit_release_issue", 32'(bus.issue_o), 32'd1);
    checkOutput("lit_release_sb", 32'(bus.sb_pending_o), 32'd0);
    cycleEnd();
    idle();
    @(negedge clk);
    checkOutput("lit_sb_rd5", 32'(bus.sb_pending_o), 32'h0000_0020);
    cycleEnd();

    // RAW on x3 held until writeback.
    doReset();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 5'd0, 0, 0);
    @(negedge clk);
    checkOutput("lit_raw_first_issue", 32'(bus.issue_o), 32'd1);
    cycleEnd();
    applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);
    checkOutput("lit_raw_pc_stall", 32'(bus.pc_stall_o), 32'd1);
    checkOutput("lit_raw_bubble", 32'(bus.id_ex_bubble_o), 32'd1);
    checkOutput("lit_raw_issue", 32'(bus.issue_o), 32'd0);
    cycleEnd();
    applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 0);
    @(negedge clk);
    checkOutput("lit_raw_wb_issue", 32'(bus.issue_o), BYPASS ? 32'd1 : 32'd0);
    cycleEnd();
    applyStimulus(1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);
    checkOutput("lit_raw_after_wb_issue", 32'(bus.issue_o), 32'd1);
    cycleEnd();

    // x0 never tracked nor stalls.
    doReset();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0);
    cycleEnd();
    applyStimulus(1, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);
    checkOutput("lit_x0_stall", 32'(bus.pc_stall_o), 32'd0);
    checkOutput("lit_x0_issue", 32'(bus.issue_o), 32'd1);
    checkOutput("lit_x0_sb", 32'(bus.sb_pending_o), 32'd0);
    cycleEnd();

    // WAW on x7 colliding with its own writeback.
    doReset();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 5'd0, 0, 0);
    cycleEnd();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 1, 5'd7, 0, 0);
    @(negedge clk);
    checkOutput("lit_waw_issue", 32'(bus.issue_o), BYPASS ? 32'd1 : 32'd0);
    cycleEnd();
    idle();
    @(negedge clk);
    checkOutput("lit_waw_sb", 32'(bus.sb_pending_o), BYPASS ? 32'h80 : 32'h0);
    cycleEnd();

    // Redirect beats busy; flush lasts two cycles, a second redirect extends it.
    doReset();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1);
    @(negedge clk);
    checkOutput("lit_redir_flush1", 32'(bus.if_id_flush_o), 32'd1);
    checkOutput("lit_redir_stall1", 32'(bus.id_ex_stall_o), 32'd0);
    checkOutput("lit_redir_state1", 32'(bus.state_o), 32'd0);
    cycleEnd();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    @(negedge clk);
    checkOutput("lit_redir_flush2", 32'(bus.if_id_flush_o), 32'd1);
    checkOutput("lit_redir_state2", 32'(bus.state_o), 32'd1);
    checkOutput("lit_redir_pcstall2", 32'(bus.pc_stall_o), 32'd0);
    cycleEnd();
    @(negedge clk);
    checkOutput("lit_redir_flush3", 32'(bus.if_id_flush_o), 32'd0);
    checkOutput("lit_redir_busy3", 32'(bus.id_ex_stall_o), 32'd1);
    cycleEnd();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1);
    cycleEnd();
    @(negedge clk);
    checkOutput("lit_ext_state2", 32'(bus.state_o), 32'd1);
    cycleEnd();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);
    checkOutput("lit_ext_flush3", 32'(bus.if_id_flush_o), 32'd1);
    checkOutput("lit_ext_state3", 32'(bus.state_o), 32'd1);
    cycleEnd();
    @(negedge clk);
    checkOutput("lit_ext_flush4", 32'(bus.if_id_flush_o), 32'd0);
    cycleEnd();

    // Busy hold masks a pending hazard; hazard then governs.
    doReset();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 1, 5'd4, 0, 5'd0, 0, 0);
    cycleEnd();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
      @(negedge clk);
      checkOutput("lit_busy_exstall", 32'(bus.id_ex_stall_o), 32'd1);
      checkOutput("lit_busy_bubble", 32'(bus.id_ex_bubble_o), 32'd0);
      checkOutput("lit_busy_issue", 32'(bus.issue_o), 32'd0);
      cycleEnd();
    end
    applyStimulus(1, 1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0);
    @(negedge clk);
    checkOutput("lit_after_busy_bubble", 32'(bus.id_ex_bubble_o), 32'd1);
    checkOutput("lit_after_busy_exstall", 32'(bus.id_ex_stall_o), 32'd0);
    cycleEnd();

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      cycleEnd();
    end

    rst_n = 1'b1;
    idle();
    cycleEnd();
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
